// File: rtl/midori_sbox_sched.sv
// Feeds a 3-share 64-bit Midori state through an external masked S-box one
// nibble per randomness word and writes the results back in place.
module midori_sbox_sched #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [63:0] sh1_in,
    input  logic [63:0] sh2_in,
    input  logic [63:0] sh3_in,
    input  logic        abort,
    input  logic        rnd_valid,
    input  logic [32:0] rnd_in,
    output logic        rnd_ready,
    output logic [3:0]  sb_in1,
    output logic [3:0]  sb_in2,
    output logic [3:0]  sb_in3,
    output logic [26:0] sb_r,
    output logic [5:0]  sb_rs,
    input  logic [3:0]  sb_out1,
    input  logic [3:0]  sb_out2,
    input  logic [3:0]  sb_out3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sh1_out,
    output logic [63:0] sh2_out,
    output logic [63:0] sh3_out
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] s1, s2, s3;
    logic [4:0]  cnt;
    logic [LAT-1:0] pipe_v;
    logic [3:0]  pipe_idx [LAT];
    logic        init_done;
    logic        issue, load_fire, out_fire, wb, ahead_busy;
    logic [3:0]  wb_idx;

    always_comb begin
        load_fire  = (state == IDLE) && init_done && load_valid && !abort;
        out_fire   = (state == DONE) && out_ready && !abort;
        issue      = (state == FEED) && rnd_valid && (cnt <= 5'd15) && !abort;
        wb         = pipe_v[LAT-1];
        wb_idx     = pipe_idx[LAT-1];
        // Entries still travelling behind the tail; the tail itself retires this edge.
        ahead_busy = 1'b0;
        for (int unsigned k = 0; k + 1 < LAT; k++) begin
            ahead_busy = ahead_busy | pipe_v[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (load_fire) state_nx = FEED;
                FEED:  if (issue && cnt == 5'd15) state_nx = DRAIN;
                DRAIN: if (!ahead_busy) state_nx = DONE;
                DONE:  if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready = (state == IDLE) && init_done;
        rnd_ready  = issue;
        sb_in1     = issue ? s1[{cnt[3:0], 2'b00} +: 4] : '0;
        sb_in2     = issue ? s2[{cnt[3:0], 2'b00} +: 4] : '0;
        sb_in3     = issue ? s3[{cnt[3:0], 2'b00} +: 4] : '0;
        sb_r       = issue ? rnd_in[26:0] : '0;
        sb_rs      = issue ? rnd_in[32:27] : '0;
        out_valid  = (state == DONE);
        sh1_out    = out_valid ? s1 : '0;
        sh2_out    = out_valid ? s2 : '0;
        sh3_out    = out_valid ? s3 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            cnt       <= '0;
            pipe_v    <= '0;
            init_done <= 1'b0;
            for (int unsigned k = 0; k < LAT; k++) pipe_idx[k] <= '0;
        end else begin
            init_done <= 1'b1;
            if (abort || out_fire) begin
                s1     <= '0;
                s2     <= '0;
                s3     <= '0;
                cnt    <= '0;
                pipe_v <= '0;
            end else begin
                if (load_fire) begin
                    s1  <= sh1_in;
                    s2  <= sh2_in;
                    s3  <= sh3_in;
                    cnt <= '0;
                end else if (wb) begin
                    s1[{wb_idx, 2'b00} +: 4] <= sb_out1;
                    s2[{wb_idx, 2'b00} +: 4] <= sb_out2;
                    s3[{wb_idx, 2'b00} +: 4] <= sb_out3;
                end
                if (issue) cnt <= cnt + 5'd1;
                pipe_v[0]   <= issue;
                pipe_idx[0] <= cnt[3:0];
                for (int unsigned k = 1; k < LAT; k++) begin
                    pipe_v[k]   <= pipe_v[k-1];
                    pipe_idx[k] <= pipe_idx[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_midori_sbox_sched.sv
// Drives a LAT=1 and a LAT=3 scheduler side by side, each with a behavioural
// masked Midori S-box, and checks results against hand-computed vectors.
module tb_midori_sbox_sched;

    localparam logic [63:0] SB_TAB = 64'h6420_5198_7FBE_3DAC;

    typedef struct {
        logic [63:0] x;
        logic [63:0] m2;
        logic [63:0] m3;
        logic [63:0] expv;
        bit          toggle;
    } vec_t;

    vec_t vecs [5];

    logic        clk, rst_n, load_valid, abort, rnd_valid, out_ready;
    logic [63:0] sh1_in, sh2_in, sh3_in;
    logic [32:0] rnd_in;
    logic [1:0]  load_ready, rnd_ready, out_valid;
    logic [3:0]  sb_in1 [2], sb_in2 [2], sb_in3 [2];
    logic [3:0]  sb_out1 [2], sb_out2 [2], sb_out3 [2];
    logic [26:0] sb_r [2];
    logic [5:0]  sb_rs [2];
    logic [63:0] sh1_out [2], sh2_out [2], sh3_out [2];

    int          nchk = 0;
    int          nerr = 0;
    int          lat_of [2];
    int          done_e [2];
    logic [4:0]  icnt [2];
    logic [63:0] ex1, ex2, ex3;

    midori_sbox_sched #(.LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[0]),
        .sh1_in(sh1_in), .sh2_in(sh2_in), .sh3_in(sh3_in), .abort(abort),
        .rnd_valid(rnd_valid), .rnd_in(rnd_in), .rnd_ready(rnd_ready[0]),
        .sb_in1(sb_in1[0]), .sb_in2(sb_in2[0]), .sb_in3(sb_in3[0]),
        .sb_r(sb_r[0]), .sb_rs(sb_rs[0]),
        .sb_out1(sb_out1[0]), .sb_out2(sb_out2[0]), .sb_out3(sb_out3[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .sh1_out(sh1_out[0]), .sh2_out(sh2_out[0]), .sh3_out(sh3_out[0])
    );

    midori_sbox_sched #(.LAT(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready[1]),
        .sh1_in(sh1_in), .sh2_in(sh2_in), .sh3_in(sh3_in), .abort(abort),
        .rnd_valid(rnd_valid), .rnd_in(rnd_in), .rnd_ready(rnd_ready[1]),
        .sb_in1(sb_in1[1]), .sb_in2(sb_in2[1]), .sb_in3(sb_in3[1]),
        .sb_r(sb_r[1]), .sb_rs(sb_rs[1]),
        .sb_out1(sb_out1[1]), .sb_out2(sb_out2[1]), .sb_out3(sb_out3[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .sh1_out(sh1_out[1]), .sh2_out(sh2_out[1]), .sh3_out(sh3_out[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Masked S-box model: shares 2/3 are fresh masks from r, share 1 carries S(x).
    function automatic logic [11:0] sbm(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [26:0] r);
        logic [3:0] y;
        y = SB_TAB[{a ^ b ^ c, 2'b00} +: 4];
        return {y ^ r[3:0] ^ r[7:4], r[3:0], r[7:4]};
    endfunction

    logic [11:0] pa [1];
    logic [11:0] pb [3];

    always @(posedge clk) begin
        pa[0] <= sbm(sb_in1[0], sb_in2[0], sb_in3[0], sb_r[0]);
        pb[0] <= sbm(sb_in1[1], sb_in2[1], sb_in3[1], sb_r[1]);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    always_comb begin
        sb_out1[0] = pa[0][11:8];
        sb_out2[0] = pa[0][7:4];
        sb_out3[0] = pa[0][3:0];
        sb_out1[1] = pb[2][11:8];
        sb_out2[1] = pb[2][7:4];
        sb_out3[1] = pb[2][3:0];
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s dut%0d actual=%h required=%h at %0t", nm, d, act, req, $time);
        end
    endtask

    // Mid-cycle monitor of the S-box feed, then advance to just after the next edge.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rnd_ready[d]) begin
                chk("issue", d,
                    64'({sb_in1[d], sb_in2[d], sb_in3[d], sb_r[d], sb_rs[d], rnd_valid}),
                    64'({ex1[{icnt[d][3:0], 2'b00} +: 4], ex2[{icnt[d][3:0], 2'b00} +: 4],
                         ex3[{icnt[d][3:0], 2'b00} +: 4], rnd_in[26:0], rnd_in[32:27], 1'b1}));
                icnt[d] = icnt[d] + 5'd1;
            end else begin
                chk("idle_sb", d, 64'({sb_in1[d], sb_in2[d], sb_in3[d], sb_r[d], sb_rs[d]}), '0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: full run with handshake; 1: abort at nibble 7; 2: reset during DRAIN of LAT=3
    task automatic run_vec(input int v, input int mode);
        logic [63:0] rr;
        ex2 = vecs[v].m2;
        ex3 = vecs[v].m3;
        ex1 = vecs[v].x ^ ex2 ^ ex3;
        icnt[0] = '0;
        icnt[1] = '0;
        load_valid = 1'b1;
        sh1_in = ex1;
        sh2_in = ex2;
        sh3_in = ex3;
        for (int d = 0; d < 2; d++) chk("load_ready_idle", d, 64'(load_ready[d]), 64'd1);
        tick();
        load_valid = 1'b0;
        sh1_in = '0;
        sh2_in = '0;
        sh3_in = '0;
        done_e[0] = -1;
        done_e[1] = -1;
        for (int e = 0; e < 80 && (done_e[0] < 0 || done_e[1] < 0); e++) begin
            for (int d = 0; d < 2; d++) if (out_valid[d] && done_e[d] < 0) done_e[d] = e;
            rnd_valid = vecs[v].toggle ? (e % 2 == 0) : 1'b1;
            rr = {$urandom, $urandom};
            rnd_in = rr[32:0];
            if (mode == 1 && e == 7) begin
                abort = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) chk("abort_rnd_ready", d, 64'(rnd_ready[d]), '0);
                tick();
                abort = 1'b0;
                rnd_valid = 1'b0;
                for (int d = 0; d < 2; d++) chk("abort_idle", d, 64'({load_ready[d], out_valid[d]}), 64'b10);
                for (int c = 0; c < 25; c++) begin
                    for (int d = 0; d < 2; d++)
                        chk("abort_quiet", d, out_valid[d] | sh1_out[d] | sh2_out[d] | sh3_out[d], '0);
                    tick();
                end
                return;
            end
            if (mode == 2 && e == 17) begin
                #2;
                rst_n = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk("rst_ctrl", d, 64'({load_ready[d], rnd_ready[d], out_valid[d]}), '0);
                    chk("rst_sh", d, sh1_out[d] | sh2_out[d] | sh3_out[d], '0);
                end
                rnd_valid = 1'b0;
                tick();
                rst_n = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    tick();
                    for (int d = 0; d < 2; d++) begin
                        chk("post_rst_ready", d, 64'(load_ready[d]), 64'd1);
                        chk("post_rst_quiet", d, out_valid[d] | sh1_out[d] | sh2_out[d] | sh3_out[d], '0);
                    end
                end
                return;
            end
            tick();
        end
        rnd_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("latency", d, 64'(done_e[d]), 64'((vecs[v].toggle ? 31 : 16) + lat_of[d]));
            chk("rnd_pulses", d, 64'(icnt[d]), 64'd16);
        end
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            for (int d = 0; d < 2; d++) begin
                chk("hold_valid", d, 64'(out_valid[d]), 64'd1);
                chk("result", d, sh1_out[d] ^ sh2_out[d] ^ sh3_out[d], vecs[v].expv);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk("no_load_in_hs", d, 64'(load_ready[d]), '0);
        tick();
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("hs_clear", d, out_valid[d] | sh1_out[d] | sh2_out[d] | sh3_out[d], '0);
            chk("ready_after_hs", d, 64'(load_ready[d]), 64'd1);
        end
    endtask

    initial begin
        vecs[0] = '{64'h0123456789ABCDEF, 64'hA5A55A5A0F0FF0F0, 64'h13579BDF2468ACE0, 64'hCAD3EBF789150246, 1'b0};
        vecs[1] = '{64'hFEDCBA9876543210, 64'hDEADBEEFCAFEF00D, 64'h0011223344556677, 64'h642051987FBE3DAC, 1'b1};
        vecs[2] = '{64'h0000000000000000, 64'hFFFF0000FFFF0000, 64'h123456789ABCDEF0, 64'hCCCCCCCCCCCCCCCC, 1'b1};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0, 64'h6666666666666666, 1'b0};
        vecs[4] = '{64'h00000000FFFFFFFF, 64'h3C3C3C3CC3C3C3C3, 64'h7777000088880000, 64'hCCCCCCCC66666666, 1'b0};
        lat_of[0] = 1;
        lat_of[1] = 3;
        rst_n = 1'b0;
        load_valid = 1'b0;
        abort = 1'b0;
        rnd_valid = 1'b0;
        rnd_in = '0;
        out_ready = 1'b0;
        sh1_in = '0;
        sh2_in = '0;
        sh3_in = '0;
        ex1 = '0;
        ex2 = '0;
        ex3 = '0;
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ctrl", d, 64'({load_ready[d], rnd_ready[d], out_valid[d]}), '0);
            chk("reset_sh", d, sh1_out[d] | sh2_out[d] | sh3_out[d], '0);
        end
        #4;
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk("ready_before_edge", d, 64'(load_ready[d]), '0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk("ready_first_edge", d, 64'(load_ready[d]), 64'd1);

        for (int v = 0; v < 5; v++) run_vec(v, 0);
        run_vec(0, 1);
        run_vec(1, 0);
        run_vec(3, 2);
        run_vec(2, 0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
